regfile_wb_arbiter: RTL



---
 rtl/regfile_pkg.sv | 16 +
 rtl/wb_rr_arbiter.sv | 49 ++++
 rtl/regfile_wb_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register file write-back path
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam int PORT_ALU = 0;
    localparam int PORT_MEM = 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - two-requester grant generator; WB_RR_ARB_EN selects round-robin over fixed priority
module wb_rr_arbiter
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

`ifdef WB_RR_ARB_EN
    // ptr_q names the port that wins the next contended cycle
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = req_i;
        ptr_d = ptr_q;
        if (req_i[PORT_ALU] && req_i[PORT_MEM]) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
        if (gnt_o[PORT_ALU]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[PORT_MEM]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Memory write-back always wins; the ALU port may starve under contention
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst_n;

    always_comb begin
        gnt_o           = 2'b00;
        gnt_o[PORT_MEM] = req_i[PORT_MEM];
        gnt_o[PORT_ALU] = req_i[PORT_ALU] & ~req_i[PORT_MEM];
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back arbiter and pending-write scoreboard (policy set by WB_RR_ARB_EN)
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              haz_rs,
    output logic              haz_rt,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] writedata,
    output logic              regwrite
);

    localparam int NREGS = 1 << ADDR_W;

    logic [1:0]        gnt;
    logic              any_gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              commit;

    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic              regwrite_q, regwrite_d;
    logic [NREGS-1:0]  busy_q, busy_d;

    wb_rr_arbiter u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({req1_valid, req0_valid}),
        .gnt_o (gnt)
    );

    assign req0_ready = gnt[PORT_ALU];
    assign req1_ready = gnt[PORT_MEM];
    assign any_gnt    = |gnt;

    always_comb begin
        sel_addr = req0_addr;
        sel_data = req0_data;
        if (gnt[PORT_MEM]) begin
            sel_addr = req1_addr;
            sel_data = req1_data;
        end
    end

    // Writes to register 0 are accepted but never reach the register file
    assign commit = any_gnt && (sel_addr != '0);

    always_comb begin
        rd_d        = rd_q;
        writedata_d = writedata_q;
        regwrite_d  = commit;
        if (commit) begin
            rd_d        = sel_addr;
            writedata_d = sel_data;
        end
    end

    // Set after clear so a same-cycle reservation of the committed index stays pending
    always_comb begin
        busy_d = busy_q;
        if (commit) begin
            busy_d[sel_addr] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q        <= '0;
            writedata_q <= '0;
            regwrite_q  <= 1'b0;
            busy_q      <= '0;
        end else begin
            rd_q        <= rd_d;
            writedata_q <= writedata_d;
            regwrite_q  <= regwrite_d;
            busy_q      <= busy_d;
        end
    end

    assign rd        = rd_q;
    assign writedata = writedata_q;
    assign regwrite  = regwrite_q;
    assign haz_rs    = busy_q[rs];
    assign haz_rt    = busy_q[rt];

endmodule
